uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_tx_baud_gen.sv | 32 +++
 rtl/uart_tx.sv | 141 ++++++++++++++
 tb/tb_uart_tx.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and bit-period sizing helpers,
// used by both the transmit and receive sides.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_t;

   // Clock cycles per line bit (integer division).
   function automatic int uart_div(input int clk_freq, input int baud_rate);
      return clk_freq / baud_rate;
   endfunction

   // Bits needed to count 0..div-1; never narrower than one bit.
   function automatic int uart_cnt_w(input int div);
      return (div > 1) ? $clog2(div) : 1;
   endfunction

endpackage

// File: rtl/uart_tx_baud_gen.sv
// Bit-period counter: counts 0..DIV-1 while enabled, ticks on DIV-1; no backpressure.
// Latency: tick is combinational from the count; disabled counter is held at 0.
module uart_tx_baud_gen #(
   parameter int DIV   = 10,
   parameter int CNT_W = 4
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_en,
   output logic o_tick
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] r_cnt;
   logic             w_at_max;

   assign w_at_max = (r_cnt == CNT_MAX);
   assign o_tick   = i_en && w_at_max;

   // Wrapping at the tick restarts every bit period at 0 with no extra control.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (!i_en || w_at_max) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, 8 data bits LSB first, optional parity, 1-2 stop bits.
// Latency: start bit on the cycle after accept; o_ready low for the whole frame.
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD_RATE  = 9600,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [7:0] i_data,
   input  logic       i_valid,
   output logic       o_ready,
   output logic       o_tx,
   output logic       o_busy,
   output logic       o_done
);

   localparam int DIV   = uart_div(CLK_FREQ, BAUD_RATE);
   localparam int CNT_W = uart_cnt_w(DIV);

   uart_state_t r_state, w_state_nxt;
   logic [7:0]  r_shift, w_shift_nxt;
   logic [2:0]  r_bit_cnt, w_bit_cnt_nxt;
   logic        r_stop_cnt, w_stop_cnt_nxt;
   logic        r_par, w_par_nxt;
   logic        r_tx, w_tx_nxt;
   logic        r_done, w_done_nxt;
   logic        w_tick;
   logic        w_baud_en;

   assign w_baud_en = (r_state != ST_IDLE);

   uart_tx_baud_gen #(
      .DIV   (DIV),
      .CNT_W (CNT_W)
   ) u_baud_gen (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_en    (w_baud_en),
      .o_tick  (w_tick)
   );

   assign o_ready = (r_state == ST_IDLE);
   assign o_busy  = !o_ready;
   assign o_tx    = r_tx;
   assign o_done  = r_done;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state    <= ST_IDLE;
         r_shift    <= '0;
         r_bit_cnt  <= '0;
         r_stop_cnt <= 1'b0;
         r_par      <= 1'b0;
         r_tx       <= 1'b1;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_shift    <= w_shift_nxt;
         r_bit_cnt  <= w_bit_cnt_nxt;
         r_stop_cnt <= w_stop_cnt_nxt;
         r_par      <= w_par_nxt;
         r_tx       <= w_tx_nxt;
         r_done     <= w_done_nxt;
      end
   end

   // Parity is captured at accept because the shift register is consumed during DATA.
   always_comb begin
      w_state_nxt    = r_state;
      w_shift_nxt    = r_shift;
      w_bit_cnt_nxt  = r_bit_cnt;
      w_stop_cnt_nxt = r_stop_cnt;
      w_par_nxt      = r_par;
      w_tx_nxt       = r_tx;
      w_done_nxt     = 1'b0;

      case (r_state)
         ST_IDLE: begin
            w_tx_nxt = 1'b1;
            if (i_valid) begin
               w_state_nxt    = ST_START;
               w_shift_nxt    = i_data;
               w_par_nxt      = (^i_data) ^ (PARITY_ODD != 0);
               w_bit_cnt_nxt  = '0;
               w_stop_cnt_nxt = 1'b0;
               w_tx_nxt       = 1'b0;
            end
         end
         ST_START: begin
            if (w_tick) begin
               w_state_nxt = ST_DATA;
               w_tx_nxt    = r_shift[0];
            end
         end
         ST_DATA: begin
            if (w_tick) begin
               if (r_bit_cnt == 3'd7) begin
                  if (PARITY_EN != 0) begin
                     w_state_nxt = ST_PARITY;
                     w_tx_nxt    = r_par;
                  end else begin
                     w_state_nxt = ST_STOP;
                     w_tx_nxt    = 1'b1;
                  end
               end else begin
                  w_shift_nxt   = {1'b0, r_shift[7:1]};
                  w_tx_nxt      = r_shift[1];
                  w_bit_cnt_nxt = r_bit_cnt + 3'd1;
               end
            end
         end
         ST_PARITY: begin
            if (w_tick) begin
               w_state_nxt = ST_STOP;
               w_tx_nxt    = 1'b1;
            end
         end
         ST_STOP: begin
            w_tx_nxt = 1'b1;
            if (w_tick) begin
               if ((STOP_BITS == 2) && !r_stop_cnt) begin
                  w_stop_cnt_nxt = 1'b1;
               end else begin
                  w_state_nxt = ST_IDLE;
                  w_done_nxt  = 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_tx_nxt    = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four parameter variants at DIV=10, table-driven frames
// plus hand-written back-to-back, ignored-request and mid-frame reset sequences.
module tb_uart_tx;

   localparam int DIV = 10;

   logic       clk;
   logic       rst_n;
   logic [7:0] data;
   logic [3:0] valid;
   logic [3:0] rdy, tx, busy, done;

   int n_pass  = 0;
   int n_total = 0;

   typedef struct {
      int         sel;
      logic [7:0] d;
      bit         pen;
      bit         par;
      int         len;
   } vec_t;

   // 0: no parity, 1 stop | 1: even parity | 2: odd parity | 3: 2 stop bits
   uart_tx #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
   u_dut0 (.i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_valid(valid[0]),
           .o_ready(rdy[0]), .o_tx(tx[0]), .o_busy(busy[0]), .o_done(done[0]));
   uart_tx #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1))
   u_dut1 (.i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_valid(valid[1]),
           .o_ready(rdy[1]), .o_tx(tx[1]), .o_busy(busy[1]), .o_done(done[1]));
   uart_tx #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1))
   u_dut2 (.i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_valid(valid[2]),
           .o_ready(rdy[2]), .o_tx(tx[2]), .o_busy(busy[2]), .o_done(done[2]));
   uart_tx #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2))
   u_dut3 (.i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_valid(valid[3]),
           .o_ready(rdy[3]), .o_tx(tx[3]), .o_busy(busy[3]), .o_done(done[3]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      else
         n_pass++;
   endtask

   // Entered at the falling edge of the first cycle after accept; returns at the
   // falling edge of the o_done cycle. poke_k >= 0 pulses a second request mid-frame.
   task automatic check_frame(input int sel, input logic [7:0] d, input bit pen, input bit par,
                              input int len, input int poke_k, input logic [7:0] poke_d);
      logic exp_bit, got;
      int   idx, ndone, nidle;
      ndone = 0;
      nidle = 0;
      got   = 1'b0;
      for (int k = 0; k < len; k++) begin
         idx = k / DIV;
         if (idx == 0)               exp_bit = 1'b0;
         else if (idx <= 8)          exp_bit = d[idx-1];
         else if (idx == 9 && pen)   exp_bit = par;
         else                        exp_bit = 1'b1;
         if (k % DIV == 0) got = exp_bit;
         if (tx[sel] !== exp_bit) got = tx[sel];
         if (done[sel] !== 1'b0) ndone++;
         if (busy[sel] !== 1'b1 || rdy[sel] !== 1'b0) nidle++;
         if (k % DIV == DIV - 1)
            chk($sformatf("dut%0d d=%02h bit%0d", sel, d, idx), got, exp_bit);
         if (poke_k >= 0 && k == poke_k) begin
            data       = poke_d;
            valid[sel] = 1'b1;
         end
         if (poke_k >= 0 && k == poke_k + 1) valid[sel] = 1'b0;
         @(negedge clk);
      end
      chk($sformatf("dut%0d d=%02h early_done", sel, d), ndone, 0);
      chk($sformatf("dut%0d d=%02h busy_in_frame", sel, d), nidle, 0);
      chk($sformatf("dut%0d d=%02h done_at_len", sel, d), done[sel], 1);
      chk($sformatf("dut%0d d=%02h ready_at_done", sel, d), rdy[sel], 1);
      chk($sformatf("dut%0d d=%02h tx_at_done", sel, d), tx[sel], 1);
   endtask

   task automatic send(input int sel, input logic [7:0] d, input bit pen, input bit par, input int len);
      @(negedge clk);
      data       = d;
      valid[sel] = 1'b1;
      @(negedge clk);
      valid[sel] = 1'b0;
      check_frame(sel, d, pen, par, len, -1, 8'h00);
   endtask

   vec_t vecs[8];
   int   cnt;

   initial begin
      vecs[0] = '{sel: 0, d: 8'hA5, pen: 0, par: 0, len: 100};
      vecs[1] = '{sel: 1, d: 8'h03, pen: 1, par: 0, len: 110};
      vecs[2] = '{sel: 2, d: 8'h03, pen: 1, par: 1, len: 110};
      vecs[3] = '{sel: 3, d: 8'hFF, pen: 0, par: 0, len: 110};
      vecs[4] = '{sel: 1, d: 8'hA5, pen: 1, par: 0, len: 110};
      vecs[5] = '{sel: 2, d: 8'h80, pen: 1, par: 0, len: 110};
      vecs[6] = '{sel: 0, d: 8'h00, pen: 0, par: 0, len: 100};
      vecs[7] = '{sel: 3, d: 8'h5A, pen: 0, par: 0, len: 110};

      rst_n = 1'b0;
      data  = 8'h00;
      valid = 4'b0000;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      chk("reset tx", tx, 4'hF);
      chk("reset ready", rdy, 4'hF);
      chk("reset busy", busy, 4'h0);
      chk("reset done", done, 4'h0);

      for (int i = 0; i < 8; i++) begin
         send(vecs[i].sel, vecs[i].d, vecs[i].pen, vecs[i].par, vecs[i].len);
         @(negedge clk);
         chk($sformatf("vec%0d single_done", i), done[vecs[i].sel], 0);
      end

      // Back-to-back: request held through the o_done cycle.
      @(negedge clk);
      data     = 8'h55;
      valid[0] = 1'b1;
      @(negedge clk);
      data = 8'hAA;
      check_frame(0, 8'h55, 0, 0, 100, -1, 8'h00);
      @(negedge clk);
      valid[0] = 1'b0;
      check_frame(0, 8'hAA, 0, 0, 100, -1, 8'h00);

      // Request and data change during DATA must be ignored.
      @(negedge clk);
      data     = 8'h0F;
      valid[0] = 1'b1;
      @(negedge clk);
      valid[0] = 1'b0;
      check_frame(0, 8'h0F, 0, 0, 100, 35, 8'hF0);
      cnt = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (busy[0] !== 1'b0 || tx[0] !== 1'b1) cnt++;
      end
      chk("ignored request no second frame", cnt, 0);

      // One-cycle reset during data bit 4 of 0x00.
      @(negedge clk);
      data     = 8'h00;
      valid[0] = 1'b1;
      @(negedge clk);
      valid[0] = 1'b0;
      repeat (55) @(negedge clk);
      chk("bit4 before reset", tx[0], 0);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("abort tx", tx[0], 1);
      chk("abort ready", rdy[0], 1);
      chk("abort busy", busy[0], 0);
      cnt = 0;
      for (int k = 0; k < 120; k++) begin
         if (done[0] !== 1'b0 || tx[0] !== 1'b1) cnt++;
         @(negedge clk);
      end
      chk("abort no done", cnt, 0);
      send(0, 8'h00, 0, 0, 100);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
